// File: rtl/usbfs_endp_rx_pkg.sv
// usbfs_endp_rx_pkg
// Shared definitions for the OUT-endpoint receive buffer:
//   - data PID encodings as carried on the one-bit PID/toggle signals
//   - endpoint state enum
//   - legality check for the MAX_PKT parameter
package usbfs_endp_rx_pkg;

    localparam logic PID_DATA0 = 1'b0;
    localparam logic PID_DATA1 = 1'b1;

    typedef enum logic {
        EP_EMPTY = 1'b0,
        EP_DRAIN = 1'b1
    } ep_state_t;

    // Full-speed bulk/interrupt payloads: power of two, 8..64 bytes.
    function automatic bit max_pkt_legal(input int n);
        return (n >= 8) && (n <= 64) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/usbfs_pkt_buf.sv
// usbfs_pkt_buf
// MAX_PKT x 8-bit packet buffer built from individual byte registers.
// Ports:
//   clk      clock
//   srst     synchronous active-high reset, clears every byte to 0
//   wr_en    write strobe
//   wr_idx   byte index to write
//   wr_byte  byte to write
//   rd_idx   byte index to read
//   rd_byte  combinational read data
module usbfs_pkt_buf #(
    parameter int MAX_PKT = 8
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       wr_en,
    input  logic [$clog2(MAX_PKT)-1:0] wr_idx,
    input  logic [7:0]                 wr_byte,
    input  logic [$clog2(MAX_PKT)-1:0] rd_idx,
    output logic [7:0]                 rd_byte
);

    localparam int IDX_W = $clog2(MAX_PKT);

    logic [7:0] bytes [MAX_PKT];

    // One register per byte so each has its own reset/enable; the read
    // side is a plain mux over the resulting array.
    for (genvar gi = 0; gi < MAX_PKT; gi++) begin : g_byte
        logic [7:0] byte_reg;

        always_ff @(posedge clk) begin
            if (srst) begin
                byte_reg <= 8'h00;
            end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                byte_reg <= wr_byte;
            end
        end

        assign bytes[gi] = byte_reg;
    end

    assign rd_byte = bytes[rd_idx];

endmodule

// File: rtl/usbfs_endp_rx.sv
// usbfs_endp_rx
// OUT-direction endpoint buffer. The receiver writes payload bytes into a
// single packet buffer, then commits (CRC good) or aborts the packet. The
// block checks the DATA0/DATA1 toggle, drops duplicates and overflows, and
// drains accepted payload to the application over a valid/ready stream.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   o_valid, i_ready, o_data     application byte stream
//   o_erReady                    buffer empty: receiver may ACK next OUT
//   o_erStall                    endpoint halt (never asserted)
//   i_erWrEn, i_erWrByte         payload byte write from receiver
//   i_erCommit, i_erAbort        end of packet: good / bad
//   i_erPid                      data PID of packet, sampled with commit
//   i_erClrToggle                force expected toggle back to DATA0
//   o_erToggle                   current expected data PID
//   o_erDiscard                  pulse: committed packet dropped
module usbfs_endp_rx
    import usbfs_endp_rx_pkg::*;
#(
    parameter int MAX_PKT = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_erReady,
    output logic       o_erStall,
    input  logic       i_erWrEn,
    input  logic [7:0] i_erWrByte,
    input  logic       i_erCommit,
    input  logic       i_erAbort,
    input  logic       i_erPid,
    input  logic       i_erClrToggle,
    output logic       o_erToggle,
    output logic       o_erDiscard
);

    localparam int NBYTES_W = $clog2(MAX_PKT + 1);
    localparam int IDX_W    = $clog2(MAX_PKT);
    localparam logic [NBYTES_W-1:0] MAX_CNT = NBYTES_W'(MAX_PKT);

    if (!max_pkt_legal(MAX_PKT)) begin : g_bad_param
        $error("usbfs_endp_rx: MAX_PKT must be a power of 2 in 8..64");
    end

    ep_state_t           state_reg;
    logic [NBYTES_W-1:0] wr_cnt_reg;
    logic                overflow_reg;
    logic [IDX_W-1:0]    rd_idx_reg;
    logic [IDX_W-1:0]    last_idx_reg;
    logic                toggle_reg;
    logic                discard_reg;

    logic                is_empty;
    logic                buf_wr_en;

    assign is_empty = (state_reg == EP_EMPTY);

    // A byte coinciding with end-of-packet is not payload; bytes beyond
    // MAX_PKT only mark overflow.
    assign buf_wr_en = is_empty && i_erWrEn && !i_erAbort && !i_erCommit
                       && (wr_cnt_reg < MAX_CNT);

    usbfs_pkt_buf #(
        .MAX_PKT (MAX_PKT)
    ) u_buf (
        .clk     (i_clk),
        .srst    (i_rst),
        .wr_en   (buf_wr_en),
        .wr_idx  (wr_cnt_reg[IDX_W-1:0]),
        .wr_byte (i_erWrByte),
        .rd_idx  (rd_idx_reg),
        .rd_byte (o_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= EP_EMPTY;
            wr_cnt_reg   <= '0;
            overflow_reg <= 1'b0;
            rd_idx_reg   <= '0;
            last_idx_reg <= '0;
            toggle_reg   <= PID_DATA0;
            discard_reg  <= 1'b0;
        end else begin
            discard_reg <= 1'b0;

            if (is_empty) begin
                if (i_erAbort) begin
                    wr_cnt_reg   <= '0;
                    overflow_reg <= 1'b0;
                end else if (i_erCommit) begin
                    wr_cnt_reg   <= '0;
                    overflow_reg <= 1'b0;
                    if (overflow_reg || (i_erPid != toggle_reg)) begin
                        // Overflow or duplicate (host missed our ACK):
                        // drop it, keep the expected toggle.
                        discard_reg <= 1'b1;
                    end else begin
                        toggle_reg <= ~toggle_reg;
                        if (wr_cnt_reg != '0) begin
                            last_idx_reg <= IDX_W'(wr_cnt_reg - NBYTES_W'(1));
                            rd_idx_reg   <= '0;
                            state_reg    <= EP_DRAIN;
                        end
                    end
                end else if (i_erWrEn) begin
                    if (wr_cnt_reg < MAX_CNT) begin
                        wr_cnt_reg <= wr_cnt_reg + NBYTES_W'(1);
                    end else begin
                        overflow_reg <= 1'b1;
                    end
                end
            end else begin
                // DRAIN: receiver traffic is ignored (it NAKs while full).
                if (i_ready) begin
                    if (rd_idx_reg == last_idx_reg) begin
                        state_reg <= EP_EMPTY;
                    end else begin
                        rd_idx_reg <= rd_idx_reg + IDX_W'(1);
                    end
                end
            end

            // Clear has the last word over any flip from a coincident commit.
            if (i_erClrToggle) begin
                toggle_reg <= PID_DATA0;
            end
        end
    end

    assign o_valid     = (state_reg == EP_DRAIN);
    assign o_erReady   = is_empty;
    assign o_erStall   = 1'b0;
    assign o_erToggle  = toggle_reg;
    assign o_erDiscard = discard_reg;

endmodule

// File: tb/tb_usbfs_endp_rx.sv
// tb_usbfs_endp_rx
// Directed stimulus for usbfs_endp_rx. Expected stream bytes and discard
// pulses are queued by the stimulus; a negedge monitor pops and compares
// whenever the DUT hands over a byte or pulses discard.
module tb_usbfs_endp_rx;

    localparam int MAX_PKT = 8;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       o_valid;
    logic       i_ready = 1'b0;
    logic [7:0] o_data;
    logic       o_erReady;
    logic       o_erStall;
    logic       i_erWrEn = 1'b0;
    logic [7:0] i_erWrByte = 8'h00;
    logic       i_erCommit = 1'b0;
    logic       i_erAbort = 1'b0;
    logic       i_erPid = 1'b0;
    logic       i_erClrToggle = 1'b0;
    logic       o_erToggle;
    logic       o_erDiscard;

    always #5 i_clk = ~i_clk;

    usbfs_endp_rx #(
        .MAX_PKT (MAX_PKT)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_erReady     (o_erReady),
        .o_erStall     (o_erStall),
        .i_erWrEn      (i_erWrEn),
        .i_erWrByte    (i_erWrByte),
        .i_erCommit    (i_erCommit),
        .i_erAbort     (i_erAbort),
        .i_erPid       (i_erPid),
        .i_erClrToggle (i_erClrToggle),
        .o_erToggle    (o_erToggle),
        .o_erDiscard   (o_erDiscard)
    );

    typedef struct {
        bit         disc;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         passes = 0;
    logic [7:0] pkt_bytes [16];

    function automatic void check(string name, logic [31:0] got, logic [31:0] req);
        checks++;
        if (got === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    endfunction

    function automatic void push_byte(logic [7:0] d);
        exp_t e;
        e.disc = 1'b0;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void push_disc();
        exp_t e;
        e.disc = 1'b1;
        e.data = 8'h00;
        exp_q.push_back(e);
    endfunction

    // ---------------- monitor ----------------
    logic       hold_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;

    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", o_valid, 1);
                if (o_valid) check("hold_data", o_data, hold_data);
            end
            if (o_erDiscard) begin
                check("discard_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("discard_event", e.disc, 1);
                    $display("monitor: discard pulse");
                end
            end
            if (o_valid && i_ready) begin
                check("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("byte_event", e.disc, 0);
                    check("stream_byte", o_data, e.data);
                    $display("monitor: byte 0x%02h (expected 0x%02h)", o_data, e.data);
                end
            end
            hold_prev = o_valid && !i_ready;
            hold_data = o_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // mode: 0 accepted (bytes queued), 1 discarded, 2 zero-length,
    //       3 accepted but not expected to drain (reset follows)
    task automatic send_pkt(input int n, input logic pid, input logic clr, input int mode);
        for (int i = 0; i < n; i++) begin
            i_erWrEn   = 1'b1;
            i_erWrByte = pkt_bytes[i];
            tick();
        end
        i_erWrEn = 1'b0;
        if (mode == 0) for (int i = 0; i < n; i++) push_byte(pkt_bytes[i]);
        if (mode == 1) push_disc();
        i_erCommit    = 1'b1;
        i_erPid       = pid;
        i_erClrToggle = clr;
        tick();
        i_erCommit    = 1'b0;
        i_erClrToggle = 1'b0;
        case (mode)
            0, 3: begin
                check("commit_valid", o_valid, 1);
                check("commit_not_ready", o_erReady, 0);
            end
            1: begin
                check("discard_pulse", o_erDiscard, 1);
                check("discard_no_valid", o_valid, 0);
            end
            default: begin
                check("zlp_no_valid", o_valid, 0);
                check("zlp_ready", o_erReady, 1);
            end
        endcase
        $display("pkt: %0d bytes pid=%0d clr=%0d mode=%0d", n, pid, clr, mode);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(o_erReady && exp_q.size() == 0) && n < 100) begin
            tick();
            n++;
        end
        check(name, n < 100, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        repeat (3) tick();
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 8'h00);
        check("rst_ready", o_erReady, 1);
        check("rst_toggle", o_erToggle, 0);
        check("rst_discard", o_erDiscard, 0);
        check("rst_stall", o_erStall, 0);
        i_rst = 1'b0;
        tick();
        check("post_rst_ready", o_erReady, 1);
        i_ready = 1'b1;

        // DATA0 11 22 33
        pkt_bytes[0] = 8'h11; pkt_bytes[1] = 8'h22; pkt_bytes[2] = 8'h33;
        send_pkt(3, 1'b0, 1'b0, 0);
        wait_idle("drain_t1");
        check("t1_toggle", o_erToggle, 1);

        // Duplicate DATA0, then DATA1 AA
        send_pkt(3, 1'b0, 1'b0, 1);
        tick();
        check("dup_toggle", o_erToggle, 1);
        check("dup_no_valid", o_valid, 0);
        wait_idle("drain_dup");
        pkt_bytes[0] = 8'hAA;
        send_pkt(1, 1'b1, 1'b0, 0);
        wait_idle("drain_aa");
        check("aa_toggle", o_erToggle, 0);

        // Full MAX_PKT packet with ready toggling
        for (int i = 0; i < 16; i++) pkt_bytes[i] = 8'(i);
        send_pkt(MAX_PKT, 1'b0, 1'b0, 0);
        for (int n = 0; n < 60 && !(o_erReady && exp_q.size() == 0); n++) begin
            i_ready = ~i_ready;
            tick();
        end
        check("full_drained", o_erReady && exp_q.size() == 0, 1);
        i_ready = 1'b1;
        check("full_toggle", o_erToggle, 1);
        send_pkt(MAX_PKT + 1, 1'b1, 1'b0, 1);
        wait_idle("drain_ovf");
        check("ovf_toggle", o_erToggle, 1);

        // Abort after two bytes
        for (int i = 1; i <= 2; i++) begin
            i_erWrEn   = 1'b1;
            i_erWrByte = 8'(i);
            tick();
        end
        i_erWrEn  = 1'b0;
        i_erAbort = 1'b1;
        tick();
        i_erAbort = 1'b0;
        check("abort_ready", o_erReady, 1);
        check("abort_no_valid", o_valid, 0);
        tick();
        check("abort_no_discard", o_erDiscard, 0);
        i_erClrToggle = 1'b1;
        tick();
        i_erClrToggle = 1'b0;
        check("clr_toggle", o_erToggle, 0);
        pkt_bytes[0] = 8'h5C;
        send_pkt(1, 1'b0, 1'b0, 0);
        wait_idle("drain_5c");
        check("5c_toggle", o_erToggle, 1);

        // Zero-length DATA1
        send_pkt(0, 1'b1, 1'b0, 2);
        check("zlp_toggle", o_erToggle, 0);

        // Receiver traffic during DRAIN is ignored
        i_ready = 1'b0;
        pkt_bytes[0] = 8'h77; pkt_bytes[1] = 8'h88;
        send_pkt(2, 1'b0, 1'b0, 0);
        i_erWrEn = 1'b1; i_erWrByte = 8'hFF;
        tick();
        i_erWrEn = 1'b0; i_erCommit = 1'b1; i_erPid = 1'b1;
        tick();
        i_erCommit = 1'b0; i_erAbort = 1'b1;
        tick();
        i_erAbort = 1'b0;
        check("ign_valid", o_valid, 1);
        check("ign_data", o_data, 8'h77);
        check("ign_toggle", o_erToggle, 1);
        i_ready = 1'b1;
        wait_idle("drain_ign");
        pkt_bytes[0] = 8'h99;
        send_pkt(1, 1'b1, 1'b0, 0);
        wait_idle("drain_99");
        check("99_toggle", o_erToggle, 0);

        // Clear toggle coincident with accepted DATA1 commit
        send_pkt(0, 1'b0, 1'b0, 2);
        check("zlp2_toggle", o_erToggle, 1);
        pkt_bytes[0] = 8'h42;
        send_pkt(1, 1'b1, 1'b1, 0);
        check("clr_commit_toggle", o_erToggle, 0);
        wait_idle("drain_42");

        // Reset mid-DRAIN
        i_ready = 1'b0;
        pkt_bytes[0] = 8'h10; pkt_bytes[1] = 8'h20;
        send_pkt(2, 1'b0, 1'b0, 3);
        check("pre_rst_toggle", o_erToggle, 1);
        i_rst = 1'b1;
        tick();
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_ready", o_erReady, 1);
        check("mid_rst_toggle", o_erToggle, 0);
        check("mid_rst_data", o_data, 8'h00);
        i_rst = 1'b0;
        tick();
        check("after_rst_valid", o_valid, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
